// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, the x0 address and the ID/EX bubble value for the operand-B path.
package id_ex_operand_stage_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic data_s;
    } idex_ctl_t;

    // Bubble: control bits all clear; the data fields of a bubble are zero as well.
    localparam idex_ctl_t IDEX_CTL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, data_s: 1'b0};

endpackage

// File: rtl/id_ex_operand_stage_reg_file.sv
// Register file: 2 read ports, 1 write port, x0 hardwired to zero.
// Latency: reads combinational with write-first bypass; writes land on the next posedge.
// Backpressure: none, the write port is always accepted.
module id_ex_operand_stage_reg_file
    import id_ex_operand_stage_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]      wd,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]      rd1,
    output logic [WIDTH-1:0]      rd2
);

    localparam int                  NREGS     = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_ok;

    assign wr_ok = we && (wa != ZERO_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wa] <= wd;
        end
    end

    // x0 check comes first so a write to x0 can never leak through the bypass.
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == ZERO_ADDR) begin
            rd1 = '0;
        end else if (wr_ok && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == ZERO_ADDR) begin
            rd2 = '0;
        end else if (wr_ok && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: register file read plus the ID/EX register feeding the operand-B mux.
// Latency: 1 cycle from ID inputs to ex_* outputs.
// Backpressure: stall holds ex_* (refreshing held operands from WB); flush inserts a bubble.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_RA1,
    input  logic [REG_ADDR_W-1:0] id_RA2,
    input  logic [WIDTH-1:0]      id_IMM,
    input  logic                  id_Data_S,
    input  logic [REG_ADDR_W-1:0] id_WA,
    input  logic                  id_RegWrite,
    input  logic                  wb_WE,
    input  logic [REG_ADDR_W-1:0] wb_WA,
    input  logic [WIDTH-1:0]      wb_WD,
    output logic                  ex_valid,
    output logic [WIDTH-1:0]      ex_RD1,
    output logic [WIDTH-1:0]      ex_RD2,
    output logic [WIDTH-1:0]      ex_IMM,
    output logic                  ex_Data_S,
    output logic [REG_ADDR_W-1:0] ex_WA,
    output logic                  ex_RegWrite
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0]      rf_rd1;
    logic [WIDTH-1:0]      rf_rd2;
    idex_ctl_t             ctl_q;
    logic [WIDTH-1:0]      rd1_q;
    logic [WIDTH-1:0]      rd2_q;
    logic [WIDTH-1:0]      imm_q;
    logic [REG_ADDR_W-1:0] wa_q;
    logic [REG_ADDR_W-1:0] ra1_q;
    logic [REG_ADDR_W-1:0] ra2_q;
    logic                  wb_hit1;
    logic                  wb_hit2;

    id_ex_operand_stage_reg_file #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (wb_WE),
        .wa  (wb_WA),
        .wd  (wb_WD),
        .ra1 (id_RA1),
        .ra2 (id_RA2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    // A held instruction must see WB writes to its sources, or it would use stale operands.
    assign wb_hit1 = wb_WE && (wb_WA != ZERO_ADDR) && (wb_WA == ra1_q);
    assign wb_hit2 = wb_WE && (wb_WA != ZERO_ADDR) && (wb_WA == ra2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q <= IDEX_CTL_BUBBLE;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
            wa_q  <= '0;
            ra1_q <= '0;
            ra2_q <= '0;
        end else if (flush || (!stall && !id_valid)) begin
            ctl_q <= IDEX_CTL_BUBBLE;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
            wa_q  <= '0;
            ra1_q <= '0;
            ra2_q <= '0;
        end else if (stall) begin
            if (wb_hit1) begin
                rd1_q <= wb_WD;
            end
            if (wb_hit2) begin
                rd2_q <= wb_WD;
            end
        end else begin
            ctl_q <= '{valid: 1'b1, reg_write: id_RegWrite, data_s: id_Data_S};
            rd1_q <= rf_rd1;
            rd2_q <= rf_rd2;
            imm_q <= id_IMM;
            wa_q  <= id_WA;
            ra1_q <= id_RA1;
            ra2_q <= id_RA2;
        end
    end

    assign ex_valid    = ctl_q.valid;
    assign ex_RD1      = rd1_q;
    assign ex_RD2      = rd2_q;
    assign ex_IMM      = imm_q;
    assign ex_Data_S   = ctl_q.data_s;
    assign ex_WA       = wa_q;
    assign ex_RegWrite = ctl_q.reg_write & ctl_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus stall and async-reset sequences.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_RA1;
    logic [4:0]  id_RA2;
    logic [31:0] id_IMM;
    logic        id_Data_S;
    logic [4:0]  id_WA;
    logic        id_RegWrite;
    logic        wb_WE;
    logic [4:0]  wb_WA;
    logic [31:0] wb_WD;
    logic        ex_valid;
    logic [31:0] ex_RD1;
    logic [31:0] ex_RD2;
    logic [31:0] ex_IMM;
    logic        ex_Data_S;
    logic [4:0]  ex_WA;
    logic        ex_RegWrite;

    int total;
    int passed;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        vld;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] imm;
        logic        ds;
        logic [4:0]  wa;
        logic        rw;
        logic        we;
        logic [4:0]  wwa;
        logic [31:0] wwd;
        logic        e_vld;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_imm;
        logic        e_ds;
        logic [4:0]  e_wa;
        logic        e_rw;
    } vec_t;

    vec_t vecs[14];

    id_ex_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_RA1      (id_RA1),
        .id_RA2      (id_RA2),
        .id_IMM      (id_IMM),
        .id_Data_S   (id_Data_S),
        .id_WA       (id_WA),
        .id_RegWrite (id_RegWrite),
        .wb_WE       (wb_WE),
        .wb_WA       (wb_WA),
        .wb_WD       (wb_WD),
        .ex_valid    (ex_valid),
        .ex_RD1      (ex_RD1),
        .ex_RD2      (ex_RD2),
        .ex_IMM      (ex_IMM),
        .ex_Data_S   (ex_Data_S),
        .ex_WA       (ex_WA),
        .ex_RegWrite (ex_RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic check_out(input string nm, input vec_t v);
        chk({nm, ".ex_valid"},    32'(ex_valid),    32'(v.e_vld));
        chk({nm, ".ex_RD1"},      ex_RD1,           v.e_rd1);
        chk({nm, ".ex_RD2"},      ex_RD2,           v.e_rd2);
        chk({nm, ".ex_IMM"},      ex_IMM,           v.e_imm);
        chk({nm, ".ex_Data_S"},   32'(ex_Data_S),   32'(v.e_ds));
        chk({nm, ".ex_WA"},       32'(ex_WA),       32'(v.e_wa));
        chk({nm, ".ex_RegWrite"}, 32'(ex_RegWrite), 32'(v.e_rw));
    endtask

    task automatic drive(input vec_t v);
        stall       = v.stall;
        flush       = v.flush;
        id_valid    = v.vld;
        id_RA1      = v.ra1;
        id_RA2      = v.ra2;
        id_IMM      = v.imm;
        id_Data_S   = v.ds;
        id_WA       = v.wa;
        id_RegWrite = v.rw;
        wb_WE       = v.we;
        wb_WA       = v.wwa;
        wb_WD       = v.wwd;
    endtask

    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_out(nm, v);
    endtask

    vec_t zero_v;
    vec_t cur;

    initial begin
        total  = 0;
        passed = 0;
        zero_v = '{0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0,0};

        //        stall flush vld ra1 ra2 imm ds wa rw | we wwa wwd | e_vld e_rd1 e_rd2 e_imm e_ds e_wa e_rw
        vecs[0]  = '{0,0,0, 0,0, 0,0,0,0, 1,1,32'h11111111, 0,0,0,0,0,0,0};
        vecs[1]  = '{0,0,1, 1,2, 32'h100,0,4,1, 1,2,32'h22222222,
                     1,32'h11111111,32'h22222222,32'h100,0,4,1};
        vecs[2]  = '{0,0,1, 1,3, 0,0,3,0, 1,3,32'hDEADBEEF,
                     1,32'h11111111,32'hDEADBEEF,0,0,3,0};
        vecs[3]  = '{0,0,1, 0,0, 5,0,1,1, 1,0,32'h12345678, 1,0,0,5,0,1,1};
        vecs[4]  = '{0,0,1, 0,3, 0,0,2,1, 0,0,0, 1,0,32'hDEADBEEF,0,0,2,1};
        vecs[5]  = '{0,0,0, 3,3, 32'h77,1,5,1, 1,7,7, 0,0,0,0,0,0,0};
        vecs[6]  = '{0,0,1, 2,7, 32'hFFFFFFF0,1,9,1, 0,0,0,
                     1,32'h22222222,7,32'hFFFFFFF0,1,9,1};
        vecs[7]  = '{0,1,1, 1,2, 5,1,3,1, 0,0,0, 0,0,0,0,0,0,0};
        vecs[8]  = '{0,0,1, 3,1, 32'hABC,0,31,1, 0,0,0,
                     1,32'hDEADBEEF,32'h11111111,32'hABC,0,31,1};
        vecs[9]  = '{1,1,1, 1,1, 9,1,2,1, 0,0,0, 0,0,0,0,0,0,0};
        vecs[10] = '{0,0,1, 7,0, 32'h42,1,8,0, 0,0,0, 1,7,0,32'h42,1,8,0};
        vecs[11] = '{1,0,1, 1,2, 32'h99,0,3,1, 1,7,32'h77, 1,32'h77,0,32'h42,1,8,0};
        vecs[12] = '{1,0,0, 1,2, 32'h99,0,3,1, 1,0,32'h5555, 1,32'h77,0,32'h42,1,8,0};
        vecs[13] = '{0,0,1, 7,2, 0,0,1,1, 0,0,0, 1,32'h77,32'h22222222,0,0,1,1};

        drive(zero_v);
        rst = 1'b1;
        #1;
        check_out("reset", zero_v);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Stall holding an operand while WB rewrites its source register.
        step("stl_wr5", '{0,0,0, 0,0, 0,0,0,0, 1,5,32'h11, 0,0,0,0,0,0,0});
        step("stl_load", '{0,0,1, 5,2, 32'h55,1,6,1, 0,0,0,
                           1,32'h11,32'h22222222,32'h55,1,6,1});
        step("stl_c1", '{1,0,1, 1,3, 32'h99,0,2,0, 0,0,0,
                         1,32'h11,32'h22222222,32'h55,1,6,1});
        step("stl_c2", '{1,0,1, 1,3, 32'h99,0,2,0, 1,5,32'h22,
                         1,32'h22,32'h22222222,32'h55,1,6,1});
        step("stl_c3", '{1,0,1, 1,3, 32'h99,0,2,0, 1,3,32'h33,
                         1,32'h22,32'h22222222,32'h55,1,6,1});
        cur = '{0,0,1, 5,3, 32'h66,0,7,1, 0,0,0, 1,32'h22,32'h22222222,32'h55,1,6,1};
        @(negedge clk);
        drive(cur);
        #1;
        check_out("stl_drop", cur);
        cur.e_rd2 = 32'h33;
        cur.e_imm = 32'h66;
        cur.e_ds  = 1'b0;
        cur.e_wa  = 5'd7;
        @(posedge clk);
        #1;
        check_out("stl_after", cur);

        // Async reset mid-cycle with a valid instruction held under stall.
        @(negedge clk);
        cur.stall = 1'b1;
        drive(cur);
        #2;
        rst = 1'b1;
        #1;
        check_out("arst", zero_v);
        #1;
        rst = 1'b0;
        step("post_rst", '{0,0,1, 5,1, 32'h10,1,2,1, 0,0,0, 1,0,0,32'h10,1,2,1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
